// File: rtl/rv32i_types.sv
// Shared pipeline types for the data-memory interface.
//   dmem_req_t   : one captured dmem request (address, lane masks, write data)
//   dmem_state_t : responder FSM states
//   lane_mask()  : expands a 4-bit byte-lane mask into a 32-bit bit mask
package rv32i_types;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_state_t;

  // Byte lane i of the result is all-ones when m[i] is set.
  function automatic logic [31:0] lane_mask(input logic [3:0] m);
    lane_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// DEPTH_WORDS x 32-bit storage array with one shared read/write port.
//   clk   : write clock (rising edge)
//   idx   : word index for both the combinational read and the write
//   we    : per-byte write enables, lane i covers bits [8i+7:8i]
//   wdata : lane-aligned write data
//   rdata : current contents of word idx (combinational)
// Contents are deliberately not reset.
module dmem_byte_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];

  // Byte-lane masked write; lanes with we[i]=0 keep their old value.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the pipeline dmem port. Serves one request at a
// time, LATENCY cycles after the request cycle, with byte-lane masking and a
// sticky protocol/range error flag.
//   clk, rst   : clock and asynchronous active-high reset
//   dmem_addr  : byte address (bits [1:0] ignored)
//   dmem_rmask : read byte lanes, nonzero = read request
//   dmem_wmask : write byte lanes, nonzero = write request
//   dmem_wdata : lane-aligned write data
//   dmem_rdata : read data, nonzero only in the dmem_resp cycle
//   dmem_resp  : one-cycle completion pulse
//   err        : sticky error (out of range, both masks, request while busy)
module dmem_responder
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1ECE_B000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

  dmem_state_t state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  dmem_req_t   req_r, req_in_s, sel_req_s;

  logic        req_valid_s;
  logic        accept_s;
  logic        done_s;
  logic        fire_nxt_s;
  logic        busy_hit_s;
  logic [31:0] off_s;
  logic        in_range_s;
  logic        bad_s;
  logic [IDX_W-1:0] ram_idx_s;
  logic [3:0]  ram_we_s;
  logic [31:0] ram_rdata_s;
  logic [31:0] rd_val_s;

  logic        resp_r;
  logic [31:0] rdata_r;
  logic        err_r;

  assign req_in_s    = '{addr: dmem_addr, rmask: dmem_rmask,
                         wmask: dmem_wmask, wdata: dmem_wdata};
  assign req_valid_s = (|dmem_rmask) | (|dmem_wmask);
  assign accept_s    = (state_r == IDLE) && req_valid_s;
  // The resp cycle: access happens at the edge that ends it.
  assign done_s      = (state_r == BUSY) && (cnt_r == CNT_ZERO);
  // A request arriving in the resp cycle is neither taken nor an error.
  assign busy_hit_s  = (state_r == BUSY) && (cnt_r != CNT_ZERO) && req_valid_s;

  // Next-state and latency counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (req_valid_s) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      BUSY: begin
        if (cnt_r != CNT_ZERO) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Outputs are registered, so the pulse is launched at the edge where the
  // FSM enters its final BUSY cycle (the accept edge itself when LATENCY=1).
  assign fire_nxt_s = (state_nxt_s == BUSY) && (cnt_nxt_s == CNT_ZERO);

  // Address decode, array access control and read-data masking. In IDLE the
  // live inputs are decoded so a LATENCY=1 response can be prepared at the
  // accept edge; otherwise the latched request is used.
  always_comb begin
    sel_req_s = req_r;
    if (state_r == IDLE) begin
      sel_req_s = req_in_s;
    end else begin
      sel_req_s = req_r;
    end
    off_s      = sel_req_s.addr - BASE_ADDR;
    in_range_s = (off_s < SPAN_BYTES);
    bad_s      = !in_range_s || ((|sel_req_s.rmask) && (|sel_req_s.wmask));
    ram_idx_s  = off_s[IDX_W+1:2];
    ram_we_s   = 4'h0;
    if (done_s && !bad_s) begin
      ram_we_s = sel_req_s.wmask;
    end else begin
      ram_we_s = 4'h0;
    end
    rd_val_s = 32'h0;
    if (!bad_s && (|sel_req_s.rmask)) begin
      rd_val_s = ram_rdata_s & lane_mask(sel_req_s.rmask);
    end else begin
      rd_val_s = 32'h0;
    end
  end

  // FSM state, counter and request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      req_r   <= '{addr: 32'h0, rmask: 4'h0, wmask: 4'h0, wdata: 32'h0};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        req_r <= req_in_s;
      end
    end
  end

  // Registered response, read data and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_r  <= 1'b0;
      rdata_r <= 32'h0;
      err_r   <= 1'b0;
    end else begin
      resp_r  <= fire_nxt_s;
      rdata_r <= fire_nxt_s ? rd_val_s : 32'h0;
      if ((fire_nxt_s && bad_s) || busy_hit_s) begin
        err_r <= 1'b1;
      end
    end
  end

  dmem_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .idx   (ram_idx_s),
    .we    (ram_we_s),
    .wdata (sel_req_s.wdata),
    .rdata (ram_rdata_s)
  );

  assign dmem_resp  = resp_r;
  assign dmem_rdata = rdata_r;
  assign err        = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a cycle-level behavioural model
// (request windows expressed as edge numbers, memory as a plain array) checked
// against the DUT every cycle, plus directed transactions with literal results.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1ECE_B000;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;
  logic        dmem_resp, err;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    lanes = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [DEPTH];
  longint      edge_n   = 0;
  longint      free_at  = 0;
  bit          pend_v   = 1'b0;
  longint      pend_due, pend_done;
  logic [31:0] pend_rdata, pend_wd;
  logic [3:0]  pend_wm;
  bit          pend_bad;
  int          pend_idx;
  bit          exp_resp = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  bit          exp_err  = 1'b0;
  logic [31:0] m_off;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      pend_v = 1'b0; exp_resp = 1'b0; exp_rdata = 32'h0; exp_err = 1'b0; free_at = 0;
    end else begin
      exp_resp = 1'b0; exp_rdata = 32'h0;
      if (pend_v && edge_n == pend_done) begin
        if (!pend_bad && pend_wm != 4'h0)
          mem_m[pend_idx] = (mem_m[pend_idx] & ~lanes(pend_wm)) | (pend_wd & lanes(pend_wm));
        pend_v = 1'b0;
      end
      if (dmem_rmask != 4'h0 || dmem_wmask != 4'h0) begin
        if (!pend_v && edge_n >= free_at) begin
          m_off    = dmem_addr - BASE;
          pend_bad = (m_off >= 32'(DEPTH * 4)) || (dmem_rmask != 4'h0 && dmem_wmask != 4'h0);
          pend_idx = int'(m_off >> 2);
          pend_wm  = dmem_wmask;
          pend_wd  = dmem_wdata;
          pend_rdata = 32'h0;
          if (!pend_bad && dmem_rmask != 4'h0) pend_rdata = mem_m[pend_idx] & lanes(dmem_rmask);
          pend_v    = 1'b1;
          pend_due  = edge_n + LAT - 1;
          pend_done = edge_n + LAT;
          free_at   = edge_n + LAT + 1;
        end else if (pend_v) begin
          exp_err = 1'b1;
        end
      end
      if (pend_v && edge_n == pend_due) begin
        exp_resp  = 1'b1;
        exp_rdata = pend_rdata;
        if (pend_bad) exp_err = 1'b1;
      end
    end
  end

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_resp", {31'h0, dmem_resp}, 32'h0);
      check("rst_rdata", dmem_rdata, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
    end else begin
      check("resp", {31'h0, dmem_resp}, {31'h0, exp_resp});
      check("rdata", dmem_rdata, exp_rdata);
      check("err", {31'h0, err}, {31'h0, exp_err});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd);
    dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
  endtask

  task automatic go_idle();
    dmem_rmask = 4'h0; dmem_wmask = 4'h0;
  endtask

  // One request presented for one cycle; returns cycles to resp (-1 on timeout).
  task automatic txn(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output logic e);
    lat = -1; rd = 32'h0; e = 1'b0;
    @(posedge clk); #1 drive(a, rm, wm, wd);
    @(posedge clk); #1 go_idle();
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (dmem_resp) begin
        lat = k; rd = dmem_rdata; e = err;
        break;
      end
    end
  endtask

  task automatic count_resps(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (dmem_resp) n++;
    end
  endtask

  int          lat, nresp;
  logic [31:0] rd, saved;
  logic        e;
  logic [31:0] ra;

  initial begin
    rst = 1'b1;
    dmem_addr = 32'h0; dmem_wdata = 32'h0; go_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_resp", {31'h0, dmem_resp}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Initialise the working region (words 0..15).
    for (int k = 0; k < 16; k++) begin
      txn(BASE + 32'(4 * k), 4'h0, 4'hF, $urandom, lat, rd, e);
      check("init_lat", lat, LAT);
    end

    // Full write, full read.
    txn(BASE + 32'd8, 4'h0, 4'hF, 32'hDEADBEEF, lat, rd, e);
    check("wr_lat", lat, LAT);
    check("wr_rdata", rd, 32'h0);
    check("wr_err", {31'h0, e}, 32'h0);
    txn(BASE + 32'd8, 4'hF, 4'h0, 32'h0, lat, rd, e);
    check("rd_lat", lat, LAT);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", {31'h0, e}, 32'h0);

    // Partial write then partial read.
    txn(BASE + 32'd8, 4'h0, 4'b0010, 32'h0000AA00, lat, rd, e);
    txn(BASE + 32'd8, 4'b0011, 4'h0, 32'h0, lat, rd, e);
    check("part_rd", rd, 32'h0000AAEF);
    txn(BASE + 32'd8, 4'hF, 4'h0, 32'h0, lat, rd, e);
    check("part_full", rd, 32'hDEADAAEF);

    // Clean random in-range traffic.
    for (int n = 0; n < 100; n++) begin
      ra = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        txn(ra, 4'h0, 4'($urandom_range(1, 15)), $urandom, lat, rd, e);
      else
        txn(ra, 4'($urandom_range(1, 15)), 4'h0, 32'h0, lat, rd, e);
      check("rand_lat", lat, LAT);
    end

    // Out-of-range read; err must stick.
    txn(BASE + 32'(4 * DEPTH), 4'hF, 4'h0, 32'h0, lat, rd, e);
    check("oor_lat", lat, LAT);
    check("oor_rdata", rd, 32'h0);
    check("oor_err", {31'h0, e}, 32'h1);
    repeat (5) @(negedge clk);
    check("oor_sticky", {31'h0, err}, 32'h1);

    // Second request while busy.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 drive(BASE + 32'd8, 4'hF, 4'h0, 32'h0);
    @(posedge clk); #1 drive(BASE + 32'd12, 4'hF, 4'h0, 32'h0);
    @(posedge clk); #1 go_idle();
    count_resps(10, nresp);
    check("busy_nresp", nresp, 1);
    check("busy_err", {31'h0, err}, 32'h1);

    // Both masks: no access, rdata 0, err.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    saved = mem_m[2];
    txn(BASE + 32'd8, 4'hF, 4'hF, ~saved, lat, rd, e);
    check("both_lat", lat, LAT);
    check("both_rdata", rd, 32'h0);
    check("both_err", {31'h0, e}, 32'h1);
    txn(BASE + 32'd8, 4'hF, 4'h0, 32'h0, lat, rd, e);
    check("both_reread", rd, saved);

    // Reset one cycle after accepting a read.
    @(posedge clk); #1 drive(BASE + 32'd8, 4'hF, 4'h0, 32'h0);
    @(posedge clk); #1 go_idle(); rst = 1'b1;
    count_resps(3, nresp);
    @(posedge clk); #1 rst = 1'b0;
    count_resps(8, nresp);
    check("rst_drop_nresp", nresp, 0);
    txn(BASE + 32'd8, 4'hF, 4'h0, 32'h0, lat, rd, e);
    check("post_rst_lat", lat, LAT);
    check("post_rst_data", rd, saved);
    check("post_rst_err", {31'h0, e}, 32'h0);

    // Free-running random traffic, including errors, held requests and resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1) == 0) begin
        go_idle();
      end else begin
        if ($urandom_range(0, 7) != 0)
          ra = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        else
          case ($urandom_range(0, 2))
            0: ra = BASE - 32'd4;
            1: ra = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
            default: ra = $urandom;
          endcase
        case ($urandom_range(0, 15))
          0: drive(ra, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), $urandom);
          1, 2, 3, 4, 5, 6, 7: drive(ra, 4'($urandom_range(1, 15)), 4'h0, $urandom);
          default: drive(ra, 4'h0, 4'($urandom_range(1, 15)), $urandom);
        endcase
      end
    end
    @(posedge clk); #1 rst = 1'b0; go_idle();
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
